// File: rtl/apb_irq_pkg.sv
// Shared constants for the APB interrupt block: register offsets, the
// unmapped-read pattern and the access-FSM encoding.
package apb_irq_pkg;

  localparam logic [7:0] RIS_OFF  = 8'h00;
  localparam logic [7:0] IM_OFF   = 8'h04;
  localparam logic [7:0] MIS_OFF  = 8'h08;
  localparam logic [7:0] ICR_OFF  = 8'h0C;
  localparam logic [7:0] EDGE_OFF = 8'h10;
  localparam logic [7:0] ISR_OFF  = 8'h14;

  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } apb_state_e;

endpackage

// File: rtl/irq_flag_capture.sv
// Per-flag input synchroniser, rising-edge detector and sticky status.
// Level-mode bits pass the synchronised flag straight through to RIS.
module irq_flag_capture #(
  parameter int unsigned N_FLAGS     = 9,
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_FLAGS-1:0] flags_i,
  input  logic [N_FLAGS-1:0] edge_i,
  input  logic [N_FLAGS-1:0] icr_i,
  input  logic [N_FLAGS-1:0] isr_i,
  input  logic [N_FLAGS-1:0] arm_i,
  output logic [N_FLAGS-1:0] ris_o
);

  logic [N_FLAGS-1:0] f_s;
  logic [N_FLAGS-1:0] f_prev_q;
  logic [N_FLAGS-1:0] rise;
  logic [N_FLAGS-1:0] sticky_q, sticky_d;

  genvar gi;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign f_s = flags_i;
  end else begin : g_sync
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      logic [N_FLAGS-1:0] stage_in;
      logic [N_FLAGS-1:0] stage_q;
      if (gi == 0) begin : g_first
        assign stage_in = flags_i;
      end else begin : g_next
        assign stage_in = g_stage[gi-1].stage_q;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q <= '0;
        else        stage_q <= stage_in;
      end
    end
    assign f_s = g_stage[SYNC_STAGES-1].stage_q;
  end

  assign rise = f_s & ~f_prev_q;

  // Set sources win over clears so an event coinciding with ICR is kept.
  always_comb begin
    sticky_d = '0;
    sticky_d = (rise | (isr_i & edge_i)) | (sticky_q & ~((icr_i & edge_i) | arm_i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_prev_q <= '0;
      sticky_q <= '0;
    end else begin
      f_prev_q <= f_s;
      sticky_q <= sticky_d;
    end
  end

  for (gi = 0; gi < N_FLAGS; gi++) begin : g_bit
    assign ris_o[gi] = edge_i[gi] ? sticky_q[gi] : f_s[gi];
  end

endmodule

// File: rtl/apb_irq_ctrl.sv
// APB slave owning interrupt status, mask, clear/set and edge-mode control
// for one peripheral, with configurable wait states and irq_o style.
module apb_irq_ctrl
  import apb_irq_pkg::*;
#(
  parameter int unsigned N_FLAGS     = 9,
  parameter int unsigned SYNC_STAGES = 0,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned IRQ_PULSE   = 0,
  parameter logic [31:0] EDGE_RESET  = '0
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [7:0]         PADDR,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  output logic               PREADY,
  output logic               PSLVERR,
  input  logic [N_FLAGS-1:0] flags_i,
  output logic               irq_o
);

  apb_state_e         state_q, state_d;
  logic [2:0]         wait_cnt_q, wait_cnt_d;
  logic [N_FLAGS-1:0] im_q, im_d;
  logic [N_FLAGS-1:0] edge_q, edge_d;
  logic [31:0]        prdata_q, prdata_d;
  logic               pslverr_q, pslverr_d;
  logic               irq_q, irq_d;
  logic               mis_any_q;

  logic [N_FLAGS-1:0] ris, mis;
  logic [N_FLAGS-1:0] icr_pulse, isr_pulse, arm_pulse;
  logic               mis_any, mapped, commit;
  logic [31:0]        rd_data;
  logic               unused_wdata;

  assign unused_wdata = ^PWDATA;
  assign mis          = ris & im_q;
  assign mis_any      = |mis;

  irq_flag_capture #(
    .N_FLAGS    (N_FLAGS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_capture (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .flags_i(flags_i),
    .edge_i (edge_q),
    .icr_i  (icr_pulse),
    .isr_i  (isr_pulse),
    .arm_i  (arm_pulse),
    .ris_o  (ris)
  );

  always_comb begin
    mapped  = 1'b1;
    rd_data = '0;
    case (PADDR)
      RIS_OFF:          rd_data[N_FLAGS-1:0] = ris;
      IM_OFF:           rd_data[N_FLAGS-1:0] = im_q;
      MIS_OFF:          rd_data[N_FLAGS-1:0] = mis;
      EDGE_OFF:         rd_data[N_FLAGS-1:0] = edge_q;
      ICR_OFF, ISR_OFF: rd_data = '0;
      default:          mapped = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (PSEL) begin
          wait_cnt_d = '0;
          state_d    = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!PSEL)                                     state_d = ST_IDLE;
        else if (wait_cnt_q == 3'(WAIT_STATES - 1))    state_d = ST_DONE;
        else                                           wait_cnt_d = wait_cnt_q + 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Response is captured on entry to DONE so it is stable for the PREADY cycle.
    prdata_d  = '0;
    pslverr_d = 1'b0;
    if (state_d == ST_DONE) begin
      if (!mapped) begin
        prdata_d  = DEADBEEF;
        pslverr_d = 1'b1;
      end else if (!PWRITE) begin
        prdata_d  = rd_data;
      end
    end
  end

  assign commit = (state_q == ST_DONE) && PSEL && PENABLE && PWRITE && mapped;

  always_comb begin
    im_d      = im_q;
    edge_d    = edge_q;
    icr_pulse = '0;
    isr_pulse = '0;
    arm_pulse = '0;
    if (commit) begin
      case (PADDR)
        IM_OFF:  im_d      = PWDATA[N_FLAGS-1:0];
        ICR_OFF: icr_pulse = PWDATA[N_FLAGS-1:0];
        ISR_OFF: isr_pulse = PWDATA[N_FLAGS-1:0];
        EDGE_OFF: begin
          edge_d    = PWDATA[N_FLAGS-1:0];
          arm_pulse = PWDATA[N_FLAGS-1:0] & ~edge_q;
        end
        default: ;
      endcase
    end
  end

  assign irq_d = (IRQ_PULSE != 0) ? (mis_any & ~mis_any_q) : mis_any;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      im_q       <= '0;
      edge_q     <= EDGE_RESET[N_FLAGS-1:0];
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      irq_q      <= 1'b0;
      mis_any_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      im_q       <= im_d;
      edge_q     <= edge_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
      irq_q      <= irq_d;
      mis_any_q  <= mis_any;
    end
  end

  assign PREADY  = (state_q == ST_DONE);
  assign PRDATA  = prdata_q;
  assign PSLVERR = pslverr_q;
  assign irq_o   = irq_q;

endmodule
